// File: rtl/fft_seq_pkg.sv
// Shared types and default sizing for the fft_fx64_it_rdx8_w008 frame sequencer.
package fft_seq_pkg;

  localparam int unsigned BEATS_DEF        = 64;
  localparam int unsigned GAP_CYCLES_DEF   = 272;
  localparam int unsigned MAX_INFLIGHT_DEF = 2;
  localparam int unsigned ID_W_DEF         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOAD = 2'd2
  } in_state_e;

  typedef enum logic {
    OIDLE  = 1'b0,
    STREAM = 1'b1
  } out_state_e;

endpackage

// File: rtl/fft_seq_id_fifo.sv
// Small in-order FIFO of frame IDs: pushed when a frame is issued to the core,
// popped when that frame's last output beat leaves. Head reads 0 when empty.
module fft_seq_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head_id
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer, occupancy and storage updates; a push into a full FIFO is only
  // accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_FULL) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_id = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Start/done sequencer for the streaming FFT core: gates input frames behind
// core_next with a minimum gap, frames the output window from next_out, and
// tracks frames in flight with sticky protocol error flags.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned BEATS        = BEATS_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned ID_W         = ID_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_enable,
  input  logic            err_clear,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            in_sop,
  output logic [5:0]      in_beat,
  output logic            core_next,
  input  logic            core_next_out,
  output logic            out_valid,
  output logic            out_sop,
  output logic            out_eop,
  output logic [ID_W-1:0] out_frame_id,
  output logic [1:0]      inflight,
  output logic            busy,
  output logic            err_underrun,
  output logic            err_overlap,
  output logic            err_spurious
);

  localparam int unsigned      GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CYCLES);
  localparam logic [5:0]       LAST_BEAT = 6'(BEATS - 1);
  localparam logic [1:0]       MAX_FL    = 2'(MAX_INFLIGHT);

  in_state_e        in_state_q, in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic [5:0]       beat_q, beat_d;
  logic [5:0]       obeat_q, obeat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [ID_W-1:0]  issue_id_q, issue_id_d;
  logic [1:0]       inflight_q, inflight_d;
  logic             spur_q, spur_d;
  logic             err_underrun_q, err_underrun_d;
  logic             err_overlap_q, err_overlap_d;
  logic             err_spurious_q, err_spurious_d;
  logic             issue, retire;
  logic [ID_W-1:0]  head_id;

  // Input FSM: wait for room and gap, pulse core_next, then stream BEATS beats.
  always_comb begin
    in_state_d = in_state_q;
    beat_d     = beat_q;
    gap_d      = (gap_q >= GAP_MAX) ? gap_q : gap_q + 1'b1;
    issue_id_d = issue_id_q;
    issue      = 1'b0;
    core_next  = 1'b0;
    in_ready   = 1'b0;
    case (in_state_q)
      IDLE: begin
        if (cfg_enable && in_valid && (inflight_q < MAX_FL) && (gap_q >= GAP_MAX)) begin
          in_state_d = ARM;
        end
      end
      ARM: begin
        core_next  = 1'b1;
        issue      = 1'b1;
        gap_d      = '0;
        issue_id_d = issue_id_q + 1'b1;
        beat_d     = '0;
        in_state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d     = '0;
          in_state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: in_state_d = IDLE;
    endcase
  end

  // Output FSM: a next_out pulse opens a BEATS-long window; pulses inside it are ignored.
  always_comb begin
    out_state_d = out_state_q;
    obeat_d     = obeat_q;
    spur_d      = spur_q;
    out_valid   = 1'b0;
    case (out_state_q)
      OIDLE: begin
        if (core_next_out) begin
          out_state_d = STREAM;
          obeat_d     = '0;
          spur_d      = (inflight_q == '0);
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (obeat_q == LAST_BEAT) begin
          obeat_d     = '0;
          out_state_d = OIDLE;
        end else begin
          obeat_d = obeat_q + 1'b1;
        end
      end
      default: out_state_d = OIDLE;
    endcase
  end

  // In-flight accounting and sticky errors; a new error event beats a same-cycle clear.
  always_comb begin
    retire = out_eop && !spur_q;
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    err_underrun_d = (err_underrun_q && !err_clear) || ((in_state_q == LOAD) && !in_valid);
    err_overlap_d  = (err_overlap_q && !err_clear) || ((out_state_q == STREAM) && core_next_out);
    err_spurious_d = (err_spurious_q && !err_clear) || (core_next_out && (inflight_q == '0));
  end

  // State registers; the gap counter resets saturated so the first frame is not delayed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q     <= IDLE;
      out_state_q    <= OIDLE;
      beat_q         <= '0;
      obeat_q        <= '0;
      gap_q          <= GAP_MAX;
      issue_id_q     <= '0;
      inflight_q     <= '0;
      spur_q         <= 1'b0;
      err_underrun_q <= 1'b0;
      err_overlap_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      in_state_q     <= in_state_d;
      out_state_q    <= out_state_d;
      beat_q         <= beat_d;
      obeat_q        <= obeat_d;
      gap_q          <= gap_d;
      issue_id_q     <= issue_id_d;
      inflight_q     <= inflight_d;
      spur_q         <= spur_d;
      err_underrun_q <= err_underrun_d;
      err_overlap_q  <= err_overlap_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  fft_seq_id_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (issue),
    .push_id (issue_id_q),
    .pop     (retire),
    .head_id (head_id)
  );

  assign in_sop       = in_ready && (beat_q == '0);
  assign in_beat      = beat_q;
  assign out_sop      = out_valid && (obeat_q == '0);
  assign out_eop      = out_valid && (obeat_q == LAST_BEAT);
  assign out_frame_id = (out_valid && !spur_q) ? head_id : '0;
  assign inflight     = inflight_q;
  assign busy         = (in_state_q != IDLE) || (inflight_q != '0);
  assign err_underrun = err_underrun_q;
  assign err_overlap  = err_overlap_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: a cycle-level reference model
// predicts frame issue, in-flight count and errors; expected beats are queued
// and checked by a separate monitor.
module tb_fft_frame_sequencer;

  localparam int BEATS = 64;
  localparam int GAP   = 272;
  localparam int MAXF  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_enable = 1'b0;
  logic       err_clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       core_next_out = 1'b0;
  logic       in_ready, in_sop, core_next;
  logic [5:0] in_beat;
  logic       out_valid, out_sop, out_eop;
  logic [3:0] out_frame_id;
  logic [1:0] inflight;
  logic       busy, err_underrun, err_overlap, err_spurious;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         sop;
    bit         eop;
    logic [3:0] id;
  } out_exp_t;

  int       in_q[$];
  out_exp_t out_q[$];

  fft_frame_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_enable    (cfg_enable),
    .err_clear     (err_clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sop        (in_sop),
    .in_beat       (in_beat),
    .core_next     (core_next),
    .core_next_out (core_next_out),
    .out_valid     (out_valid),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_frame_id  (out_frame_id),
    .inflight      (inflight),
    .busy          (busy),
    .err_underrun  (err_underrun),
    .err_overlap   (err_overlap),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit en, input bit clr, input bit nxt);
    @(posedge clk);
    #1;
    in_valid      = v;
    cfg_enable    = en;
    err_clear     = clr;
    core_next_out = nxt;
  endtask

  // Hold a frame request until core_next appears; returns its cycle or -1.
  task automatic waitIssue(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1, 1, 0, 0);
      if (core_next === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checkOutput("issue_timeout", 0, 1);
  endtask

  task automatic waitEop(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (out_eop === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checkOutput("eop_timeout", 0, 1);
  endtask

  task automatic loadBeats(input int n);
    repeat (n) applyStimulus(1, 1, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 1, 0, 0);
  endtask

  task automatic retireOne();
    applyStimulus(0, 1, 0, 1);
    idle(BEATS + 2);
  endtask

  // Reference model, evaluated once per cycle on sampled inputs.
  bit         pend_issue, has_last, has_win, win_spur;
  int         last_issue, win_start, m_inflight;
  bit         m_under, m_over, m_spur;
  logic [3:0] out_id;

  always @(negedge clk) begin : model
    bit       exp_cn, in_load, in_frame, win_active, eop_now;
    bit       ev_under, ev_over, ev_spur, next_pend;
    out_exp_t e;
    if (!reset_n) begin
      pend_issue = 0; has_last = 0; has_win = 0; win_spur = 0;
      m_inflight = 0; m_under = 0; m_over = 0; m_spur = 0; out_id = '0;
      in_q.delete();
      out_q.delete();
      checkOutput("reset_outputs",
                  {in_ready, in_sop, in_beat, core_next, out_valid, out_sop, out_eop,
                   out_frame_id, inflight, busy, err_underrun, err_overlap, err_spurious}, 0);
    end else begin
      exp_cn     = pend_issue;
      in_load    = has_last && (cyc >= last_issue + 1) && (cyc <= last_issue + BEATS);
      in_frame   = exp_cn || (has_last && (cyc <= last_issue + BEATS));
      win_active = has_win && (cyc >= win_start + 1) && (cyc <= win_start + BEATS);
      eop_now    = win_active && (cyc == win_start + BEATS);

      checkOutput("core_next", core_next, exp_cn);
      checkOutput("inflight", inflight, m_inflight);
      checkOutput("busy", busy, in_frame || (m_inflight != 0));
      checkOutput("err_underrun", err_underrun, m_under);
      checkOutput("err_overlap", err_overlap, m_over);
      checkOutput("err_spurious", err_spurious, m_spur);

      ev_under  = in_load && !in_valid;
      ev_over   = core_next_out && win_active;
      ev_spur   = core_next_out && (m_inflight == 0);
      next_pend = in_valid && cfg_enable && (m_inflight < MAXF) && !exp_cn &&
                  (!has_last || (cyc + 1 >= last_issue + GAP + 2));

      if (exp_cn) begin
        has_last   = 1;
        last_issue = cyc;
        for (int b = 0; b < BEATS; b++) in_q.push_back(b);
      end
      if (core_next_out && !win_active) begin
        has_win   = 1;
        win_start = cyc;
        win_spur  = (m_inflight == 0);
        for (int b = 0; b < BEATS; b++) begin
          e.sop = (b == 0);
          e.eop = (b == BEATS - 1);
          e.id  = win_spur ? 4'd0 : out_id;
          out_q.push_back(e);
        end
        if (!win_spur) out_id = out_id + 4'd1;
      end
      if (exp_cn) m_inflight++;
      if (eop_now && !win_spur) m_inflight--;
      m_under    = (m_under && !err_clear) || ev_under;
      m_over     = (m_over && !err_clear) || ev_over;
      m_spur     = (m_spur && !err_clear) || ev_spur;
      pend_issue = next_pend;
    end
  end

  // Monitor: pops expected beats whenever the DUT presents an input or output beat.
  always @(negedge clk) begin : monitor
    int       b;
    out_exp_t e;
    if (reset_n) begin
      if (in_ready === 1'b1) begin
        if (in_q.size() == 0) begin
          checkOutput("in_ready_unexpected", in_ready, 0);
        end else begin
          b = in_q.pop_front();
          checkOutput("in_beat", in_beat, b);
          checkOutput("in_sop", in_sop, b == 0);
        end
      end
      if (out_valid === 1'b1) begin
        if (out_q.size() == 0) begin
          checkOutput("out_valid_unexpected", out_valid, 0);
        end else begin
          e = out_q.pop_front();
          checkOutput("out_sop", out_sop, e.sop);
          checkOutput("out_eop", out_eop, e.eop);
          checkOutput("out_frame_id", out_frame_id, e.id);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int c1, c2, c3, d, e, r, k;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single frame, then one output window.
    waitIssue(20, c1);
    loadBeats(BEATS);
    idle($urandom_range(5, 40));
    retireOne();
    checkOutput("t1_inflight_after", inflight, 0);

    // Back-to-back frames with in_valid held high.
    waitIssue(400, c1);
    waitIssue(400, c2);
    checkOutput("t2_issue_spacing", c2 - c1, GAP + 2);
    loadBeats(BEATS);
    idle($urandom_range(1, 20));
    retireOne();
    retireOne();

    // Third frame held off by the in-flight limit.
    waitIssue(400, c1);
    waitIssue(400, c2);
    loadBeats(BEATS + 500);
    checkOutput("t3_held_inflight", inflight, 2);
    applyStimulus(1, 1, 0, 1);
    d = cyc;
    waitIssue(200, c3);
    checkOutput("t3_release_latency", c3 - d, BEATS + 2);
    loadBeats(BEATS);
    idle(10);
    retireOne();
    retireOne();

    // Underrun at beat 10, clear, then clear colliding with a new underrun.
    waitIssue(400, c1);
    loadBeats(10);
    applyStimulus(0, 1, 0, 0);
    loadBeats(BEATS - 11);
    idle(1);
    checkOutput("t4_underrun_set", err_underrun, 1);
    applyStimulus(0, 1, 1, 0);
    idle(1);
    checkOutput("t4_underrun_cleared", err_underrun, 0);
    waitIssue(400, c1);
    k = $urandom_range(1, BEATS - 2);
    loadBeats(k);
    applyStimulus(0, 1, 1, 0);
    loadBeats(BEATS - 1 - k);
    idle(1);
    checkOutput("t4_clear_vs_event", err_underrun, 1);
    retireOne();
    retireOne();
    applyStimulus(0, 1, 1, 0);

    // Overlapping next_out at output beat 30, then a spurious one.
    waitIssue(400, c1);
    loadBeats(BEATS);
    applyStimulus(0, 1, 0, 1);
    d = cyc;
    idle(30);
    applyStimulus(0, 1, 0, 1);
    waitEop(BEATS, e);
    checkOutput("t5_eop_position", e - d, BEATS);
    idle(1);
    checkOutput("t5_overlap_set", err_overlap, 1);
    idle(3);
    applyStimulus(0, 1, 0, 1);
    idle(1);
    checkOutput("t5_spurious_set", err_spurious, 1);
    idle(BEATS + 2);
    applyStimulus(0, 1, 1, 0);

    // Asynchronous reset mid-LOAD, then an immediate new frame.
    waitIssue(400, c1);
    loadBeats(20);
    applyStimulus(1, 1, 0, 0);
    checkOutput("t6_beat20_before_reset", in_beat, 20);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_async_reset_outputs",
                {in_ready, in_sop, in_beat, core_next, out_valid, inflight, busy,
                 err_underrun, err_overlap, err_spurious}, 0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b1;
    r = cyc;
    applyStimulus(1, 1, 0, 0);
    checkOutput("t6_no_gap_wait", {core_next, 32'(cyc - r)}, {1'b1, 32'd1});
    loadBeats(BEATS);
    idle(5);
    retireOne();

    // Randomized traffic checked entirely by the model and monitor.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom % 10) != 0, ($urandom % 50) != 0,
                    ($urandom % 200) == 0, ($urandom % 90) == 0);
    end
    repeat (BEATS + 5) applyStimulus(0, 0, 0, 0);
    checkOutput("drain_in_queue", in_q.size(), 0);
    checkOutput("drain_out_queue", out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
